mul_fu: RTL and testbench
=========================

MUL_FU -- requirements
Module: mul_fu

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter RADIX_BITS, default 2: multiplier bits retired per cycle; SHALL divide WIDTH evenly.
REQ-003 Parameter TAG_W, default 5: ROB tag width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  kill any in-flight op (branch mispredict).
REQ-007 in_valid  input  1  issue request.
REQ-008 in_ready  output  1  unit can accept this cycle.
REQ-009 mulop  input  2  mul_op_t: MUL_LO, MULH, MULHSU, MULHU.
REQ-010 a, b  input  WIDTH each  rs1 and rs2 operands.
REQ-011 tag_in  input  TAG_W  ROB index.
REQ-012 rvfi_in  input  rvfi_data  retirement-trace payload.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  CDB grant.
REQ-015 result  output  WIDTH  selected product half.
REQ-016 tag_out  output  TAG_W  tag of completed op.
REQ-017 rvfi_out  output  rvfi_data  captured payload with rd_wdata = result.

Function
REQ-018 FSM states: IDLE, BUSY, DONE.
REQ-019 in_ready = 1 in IDLE, or in DONE while out_ready = 1 (back-to-back accept); 0 in BUSY; 0 whenever flush = 1.
REQ-020 Accept (in_valid & in_ready) latches mulop, tag_in, rvfi_in and operand magnitudes, clears accumulator and count, enters BUSY.
REQ-021 Signedness: MUL_LO and MULH treat both signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
REQ-022 Signed operands converted to magnitude; a sign-flip flag is recorded = sign(a) XOR sign(b), counting only signed operands.
REQ-023 BUSY: each cycle adds magnitude(a) times the next RADIX_BITS of magnitude(b), shifted appropriately, into a 2*WIDTH-bit unsigned accumulator.
REQ-024 BUSY lasts exactly WIDTH/RADIX_BITS cycles (16 at defaults); the final cycle applies two's-complement negation of the 2*WIDTH product if sign-flip set, then enters DONE.
REQ-025 Latency accept-edge to out_valid high = WIDTH/RADIX_BITS + 1 cycles.
REQ-026 result = product[WIDTH-1:0] for MUL_LO, product[2*WIDTH-1:WIDTH] otherwise; result = 0 whenever out_valid = 0.
REQ-027 DONE: out_valid = 1 and result/tag_out/rvfi_out held stable until out_ready = 1.
REQ-028 DONE with out_ready = 1: go to BUSY if a new op accepted same cycle, else IDLE.
REQ-029 rvfi_out equals captured payload with rd_wdata replaced by result; when out_valid = 0, rvfi_out is the captured payload with rd_wdata = 0.
REQ-030 Zero operand still takes full latency (no early-out).
REQ-031 flush = 1 in any state: next state IDLE, out_valid = 0 next cycle, no accept that cycle, in-progress result discarded.
REQ-032 flush and out_ready both 1 in DONE: the completion handshake counts (result consumed that cycle), then IDLE.

Reset
REQ-033 rst low asynchronously forces IDLE, out_valid = 0, result = 0, tag_out = 0, accumulator, count and captured payload cleared.
REQ-034 Reset mid-BUSY or mid-DONE abandons the op; no out_valid pulse after rst releases.
REQ-035 in_ready = 1 on the first edge after rst deasserts.

Structure
REQ-036 mul_op_t enum, the FSM state enum and the WIDTH default belong in rv32i_types; rvfi_data reused from it.
REQ-037 One sub-module, mul_sign_fix: combinational magnitude conversion in and conditional 2*WIDTH negation out; the FSM/datapath stays in mul_fu.

Verification
REQ-038 MUL_LO a=7, b=-3 (0xFFFFFFFD) -> after 17 cycles out_valid=1, result=0xFFFFFFEB.
REQ-039 MULH a=b=0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0x80000000, b=0x80000000 -> 0xC0000000.
REQ-040 DONE with out_ready=0 for 5 cycles, then 1 with new in_valid -> result/tag stable 5 cycles; new op accepted on grant edge, next out_valid 17 cycles later.
REQ-041 flush asserted on BUSY cycle 8 -> out_valid never rises for that tag; in_ready=1 the following cycle.
REQ-042 rst pulled low mid-BUSY -> outputs zero immediately (no clock edge); no completion after release.
REQ-043 WIDTH=16, RADIX_BITS=4: MULHU a=0xFFFF, b=0xFFFF -> result=0xFFFE after 5 cycles.

Source files
------------

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types -- shared types for the RV32 core.
//   XLEN / MUL_WIDTH : architectural register width and multiplier default
//   mul_op_t         : M-extension multiply flavours
//   mul_state_t      : multiplier unit FSM states
//   rvfi_data        : retirement-trace payload carried alongside each op
//   op_signed_a/b    : which operands a multiply flavour treats as signed
// -----------------------------------------------------------------------------
package rv32i_types;

  localparam int XLEN      = 32;
  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic            valid;
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
  } rvfi_data;

  // rs1 is signed for every flavour except MULHU.
  function automatic logic op_signed_a(input mul_op_t op);
    return (op != MULHU);
  endfunction

  // rs2 is signed only for MUL_LO and MULH.
  function automatic logic op_signed_b(input mul_op_t op);
    return (op == MUL_LO) || (op == MULH);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// -----------------------------------------------------------------------------
// mul_sign_fix -- combinational sign handling around an unsigned multiplier.
//   Inbound : converts operands a/b to magnitudes according to mulop and
//             reports flip = sign(a) ^ sign(b) (signed operands only).
//   Outbound: two's-complement negates the 2*WIDTH product when neg is set.
// Ports:
//   mulop, a, b        in   operation and raw operands
//   mag_a, mag_b, flip out  operand magnitudes and result-negate flag
//   neg, prod_in       in   negate request and unsigned product
//   prod_out           out  signed-corrected product
// -----------------------------------------------------------------------------
module mul_sign_fix
  import rv32i_types::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  mul_op_t            mulop,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               flip,
  input  logic               neg,
  input  logic [2*WIDTH-1:0] prod_in,
  output logic [2*WIDTH-1:0] prod_out
);

  logic neg_a;
  logic neg_b;

  assign neg_a = op_signed_a(mulop) & a[WIDTH-1];
  assign neg_b = op_signed_b(mulop) & b[WIDTH-1];

  // The most negative value maps onto itself, which is its correct unsigned
  // magnitude (2^(WIDTH-1)), so no extra bit is needed.
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;
  assign flip  = neg_a ^ neg_b;

  assign prod_out = neg ? -prod_in : prod_in;

endmodule

// File: rtl/mul_fu.sv
// -----------------------------------------------------------------------------
// mul_fu -- iterative radix-2^RADIX_BITS multiplier functional unit.
// Accepts one op at a time, retires RADIX_BITS multiplier bits per cycle
// through a shift-and-add datapath, and presents the selected product half on
// a valid/ready completion port tagged with its ROB index and trace payload.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               kill any in-flight op
//   in_valid/in_ready   issue handshake
//   mulop, a, b         operation and rs1/rs2 operands
//   tag_in, rvfi_in     ROB tag and retirement payload of the issued op
//   out_valid/out_ready completion handshake (CDB grant)
//   result              selected product half, 0 while out_valid is low
//   tag_out, rvfi_out   tag and payload of the completed op
// -----------------------------------------------------------------------------
module mul_fu
  import rv32i_types::*;
#(
  parameter int WIDTH      = MUL_WIDTH,
  parameter int RADIX_BITS = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mul_op_t          mulop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  input  rvfi_data         rvfi_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output rvfi_data         rvfi_out
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;

  if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
    $error("mul_fu: RADIX_BITS must divide WIDTH evenly");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mul_state_t       state_q, state_d;
  mul_op_t          op_q;
  logic [TAG_W-1:0] tag_q;
  rvfi_data         rvfi_q;
  logic [PW-1:0]    a_sh_q;   // |a| pre-shifted to the weight of the next digit
  logic [WIDTH-1:0] b_sh_q;   // |b| with retired digits shifted out
  logic             flip_q;
  logic [PW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_step;
  logic [RADIX_BITS-1:0] digit;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    prod_fixed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             flip;

  mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .mulop    (mulop),
    .a        (a),
    .b        (b),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .flip     (flip),
    .neg      (flip_q),
    .prod_in  (acc_sum),
    .prod_out (prod_fixed)
  );

  // ---------------------------------------------------------------------------
  // Datapath arithmetic: one RADIX_BITS digit of |b| per BUSY cycle. The
  // shifted |a| never exceeds 2^(2*WIDTH-RADIX_BITS), so the PW-bit product
  // of it and a digit cannot overflow.
  // ---------------------------------------------------------------------------
  assign digit     = b_sh_q[RADIX_BITS-1:0];
  assign partial   = a_sh_q * PW'(digit);
  assign acc_sum   = acc_q + partial;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  // ---------------------------------------------------------------------------
  // Next-state / handshake logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;

    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;   // back-to-back accept on the grant edge
      default: in_ready = 1'b0;
    endcase
    if (flush) in_ready = 1'b0;

    accept = in_valid & in_ready;

    unique case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase

    // A flush in DONE with out_ready high still counts as consumed: the
    // handshake is visible to the consumer this cycle, we just go idle.
    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the datapath registers are reset as well (not just the FSM) because
  // tag_out and rvfi_out are driven straight from them and must read zero
  // while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= MUL_LO;
      tag_q  <= '0;
      rvfi_q <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      flip_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      op_q   <= mulop;
      tag_q  <= tag_in;
      rvfi_q <= rvfi_in;
      a_sh_q <= PW'(mag_a);
      b_sh_q <= mag_b;
      flip_q <= flip;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == BUSY && !flush) begin
      // Final digit folds in the sign correction so DONE holds the signed
      // product directly.
      acc_q  <= last_step ? prod_fixed : acc_sum;
      a_sh_q <= a_sh_q << RADIX_BITS;
      b_sh_q <= b_sh_q >> RADIX_BITS;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Completion outputs
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q == DONE);
  assign tag_out   = tag_q;

  always_comb begin
    result = '0;
    if (out_valid) begin
      result = (op_q == MUL_LO) ? acc_q[WIDTH-1:0] : acc_q[PW-1:WIDTH];
    end
    rvfi_out          = rvfi_q;
    rvfi_out.rd_wdata = XLEN'(result);
  end

endmodule

// File: tb/tb_mul_fu.sv
// -----------------------------------------------------------------------------
// tb_mul_fu -- scoreboard bench for mul_fu.
// Stimulus pushes the hand-computed expected completion into a queue at the
// accept edge; a monitor on the falling edge compares every presented output
// against the queue head and pops it on the grant. A second instance runs at
// WIDTH=16, RADIX_BITS=4 with its own queue and monitor.
// -----------------------------------------------------------------------------
module tb_mul_fu;
  import rv32i_types::*;

  localparam int W    = 32;
  localparam int R    = 2;
  localparam int TW   = 5;
  localparam int LAT  = W / R + 1;
  localparam int W2   = 16;
  localparam int R2   = 4;
  localparam int LAT2 = W2 / R2 + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b1;
  mul_op_t          mulop = MUL_LO;
  logic [TW-1:0]    tag_in = '0;
  rvfi_data         rvfi_in = '0;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0, b = '0;
  logic             out_valid;
  logic [W-1:0]     result;
  logic [TW-1:0]    tag_out;
  rvfi_data         rvfi_out;

  logic             in_valid2 = 1'b0;
  logic             in_ready2;
  logic [W2-1:0]    a2 = '0, b2 = '0;
  logic             out_valid2;
  logic [W2-1:0]    result2;
  logic [TW-1:0]    tag_out2;
  rvfi_data         rvfi_out2;

  mul_fu #(.WIDTH(W), .RADIX_BITS(R), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mulop(mulop), .a(a), .b(b), .tag_in(tag_in), .rvfi_in(rvfi_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .rvfi_out(rvfi_out)
  );

  mul_fu #(.WIDTH(W2), .RADIX_BITS(R2), .TAG_W(TW)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .mulop(mulop), .a(a2), .b(b2), .tag_in(tag_in), .rvfi_in(rvfi_in),
    .out_valid(out_valid2), .out_ready(out_ready),
    .result(result2), .tag_out(tag_out2), .rvfi_out(rvfi_out2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic [31:0]   insn;
    int            acc_edge;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];

  function automatic logic [31:0] insn_of(input logic [TW-1:0] t);
    return 32'h0200_0033 | 32'(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  bit first_seen  = 1'b0;
  bit first_seen2 = 1'b0;

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (q.size() == 0) begin
        check("spurious out_valid", out_valid, 1'b0);
      end else begin
        if (!first_seen) begin
          check("latency", 64'(cyc - q[0].acc_edge + 1), LAT);
          first_seen = 1'b1;
        end
        check("result", result, q[0].res);
        check("tag_out", tag_out, q[0].tag);
        check("rvfi_insn", rvfi_out.insn, q[0].insn);
        check("rvfi_rd_wdata", rvfi_out.rd_wdata, q[0].res);
        if (out_ready) begin
          void'(q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid2) begin
      if (q2.size() == 0) begin
        check("w16 spurious out_valid", out_valid2, 1'b0);
      end else begin
        if (!first_seen2) begin
          check("w16 latency", 64'(cyc - q2[0].acc_edge + 1), LAT2);
          first_seen2 = 1'b1;
        end
        check("w16 result", result2, q2[0].res[W2-1:0]);
        check("w16 tag_out", tag_out2, q2[0].tag);
        if (out_ready) begin
          void'(q2.pop_front());
          first_seen2 = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic set_payload(input logic [TW-1:0] t);
    tag_in           = t;
    rvfi_in          = '0;
    rvfi_in.valid    = 1'b1;
    rvfi_in.insn     = insn_of(t);
    rvfi_in.rd_addr  = t;
    rvfi_in.rd_wdata = 32'hBAAD_F00D;  // must be replaced by the unit
  endtask

  task automatic issue(input mul_op_t op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [TW-1:0] t, input logic [W-1:0] exp_res, input bit track);
    int waited = 0;
    mulop = op; a = av; b = bv;
    set_payload(t);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("issue accept timeout", in_ready, 1'b1);
    else if (track) q.push_back(exp_t'{exp_res, t, insn_of(t), cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue2(input mul_op_t op, input logic [W2-1:0] av, input logic [W2-1:0] bv,
                        input logic [TW-1:0] t, input logic [W2-1:0] exp_res);
    int waited = 0;
    mulop = op; a2 = av; b2 = bv;
    set_payload(t);
    in_valid2 = 1'b1;
    @(negedge clk);
    while (!in_ready2 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready2) check("w16 issue accept timeout", in_ready2, 1'b1);
    else q2.push_back(exp_t'{W'(exp_res), t, insn_of(t), cyc + 1});
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || q2.size() != 0) && k < 200) begin
      k++;
      @(negedge clk);
    end
    check("drain outstanding", 64'(q.size() + q2.size()), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    mul_op_t       op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] t;
    logic [W-1:0]  r;
  } vec_t;

  vec_t vecs[10] = '{
    '{MUL_LO, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB},
    '{MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000},
    '{MULHU,  32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000},
    '{MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'hC000_0000},
    '{MUL_LO, 32'd0,         32'h1234_5678, 5'd5,  32'h0000_0000},
    '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE},
    '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000},
    '{MUL_LO, 32'h1234_5678, 32'h0000_0010, 5'd8,  32'h2345_6780},
    '{MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd9,  32'h3FFF_FFFF},
    '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF}
  };

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;

    // Reset state
    #12;
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, '0);
    check("reset tag_out", tag_out, '0);
    check("reset rvfi insn", rvfi_out.insn, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", in_ready, 1'b1);

    // Directed vectors, issued back-to-back with out_ready held high
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].r, 1'b1);
    end
    drain();

    // Stall in DONE for 5 cycles, then grant together with a new issue
    out_ready = 1'b0;
    issue(MUL_LO, 32'd3, 32'd5, 5'd11, 32'd15, 1'b1);
    k = 0;
    while (!out_valid && k < 40) begin
      k++;
      @(negedge clk);
    end
    check("stall out_valid seen", out_valid, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(MULHU, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'd1, 1'b1);
    drain();

    // Flush on the 8th BUSY cycle: the op must never complete
    issue(MUL_LO, 32'd9, 32'd9, 5'd13, 32'd81, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("in_ready during flush", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("in_ready after flush", in_ready, 1'b1);
    check("out_valid after flush", out_valid, 1'b0);
    check("idle rvfi rd_wdata", rvfi_out.rd_wdata, '0);
    check("idle rvfi insn kept", rvfi_out.insn, insn_of(5'd13));
    repeat (25) @(negedge clk);

    // Asynchronous reset mid-BUSY
    @(posedge clk); #1;
    issue(MULHU, 32'hFFFF_FFFF, 32'd3, 5'd14, 32'd2, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst result", result, '0);
    check("async rst tag_out", tag_out, '0);
    check("async rst rvfi insn", rvfi_out.insn, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    @(posedge clk); #1;
    issue(MULH, 32'hFFFF_FFF9, 32'd6, 5'd15, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Narrow instance: WIDTH=16, RADIX_BITS=4
    issue2(MULHU,  16'hFFFF, 16'hFFFF, 5'd16, 16'hFFFE);
    issue2(MUL_LO, 16'h00FF, 16'hFF00, 5'd17, 16'h0100);
    issue2(MULH,   16'h8000, 16'h7FFF, 5'd18, 16'hC000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
